// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced active-low button with press/release pulses and press counter
// Optional long-press detector enabled by defining BUTTON_LONG_PRESS_EN.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count,
  output logic       long_press
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             press_accept;

  // Flops reset to 1 so a released button looks idle straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s            = ~sync2;
  assign press_accept = (state == PRESS_WAIT) && s && (cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!s) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

  logic [CNT_W-1:0] hold_cnt;

  // Only a fresh press restarts the hold count, so release bounces cannot re-arm the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_accept) begin
        hold_cnt <= '0;
      end else if (state == PRESSED || state == RELEASE_WAIT) begin
        if (hold_cnt != LONG_LAST) begin
          hold_cnt   <= hold_cnt + 1'b1;
          long_press <= (hold_cnt == LONG_PRE);
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  // Constant zero; the parameter reference keeps the unused long-press setting visible.
  assign long_press = (LONG_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce (N=8, L=20)
// Honours BUTTON_LONG_PRESS_EN when the design is built with it.
module tb_button_debounce;

  localparam int N   = 8;
  localparam int L   = 20;
  localparam int LAT = N + 3;
`ifdef BUTTON_LONG_PRESS_EN
  localparam int LP_EXP = 1;
`else
  localparam int LP_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;
  logic       long_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(N),
    .LONG_CYCLES    (L),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] cnt;
  } evt_t;

  typedef struct {
    logic       btn;
    int         hold;
    logic       lvl;
    logic [7:0] cnt;
    int         evt;
  } vec_t;

  evt_t       sb[$];
  vec_t       vecs[15];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         lp_seen = 0;
  int         rel_seen = 0;
  logic [7:0] exp_count = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a negedge; changes the input just after it and queues the expected event.
  task automatic drive(input logic val, input int evt);
    #1;
    btn_n = val;
    if (evt == 1) begin
      exp_count = exp_count + 8'd1;
      sb.push_back('{1, cyc + LAT, exp_count});
    end else if (evt == 2) begin
      sb.push_back('{2, cyc + LAT, exp_count});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (press_pulse || release_pulse) begin
        evt_t e;
        int   kind;
        kind = press_pulse ? 1 : 2;
        if (release_pulse) rel_seen++;
        check("pulse_exclusive", int'(press_pulse & release_pulse), 0);
        if (sb.size() == 0) begin
          check("unexpected_event", kind, 0);
        end else begin
          e = sb.pop_front();
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.cyc);
          check("event_count", int'(press_count), int'(e.cnt));
          check("event_level", int'(btn_level), (kind == 1) ? 1 : 0);
        end
      end
      if (long_press) lp_seen++;
    end
  end

  initial begin
    int lp_before;
    int rel_before;

    vecs[0]  = '{1'b1, 50, 1'b0, 8'd0, 0};
    vecs[1]  = '{1'b0,  5, 1'b0, 8'd0, 0};
    vecs[2]  = '{1'b1, 20, 1'b0, 8'd0, 0};
    vecs[3]  = '{1'b0,  1, 1'b0, 8'd0, 0};
    vecs[4]  = '{1'b1, 12, 1'b0, 8'd0, 0};
    vecs[5]  = '{1'b0, 14, 1'b1, 8'd1, 1};
    vecs[6]  = '{1'b1, 14, 1'b0, 8'd1, 2};
    vecs[7]  = '{1'b0, 12, 1'b1, 8'd2, 1};
    vecs[8]  = '{1'b1,  3, 1'b1, 8'd2, 0};
    vecs[9]  = '{1'b0,  2, 1'b1, 8'd2, 0};
    vecs[10] = '{1'b1, 14, 1'b0, 8'd2, 2};
    vecs[11] = '{1'b0,  7, 1'b0, 8'd2, 0};
    vecs[12] = '{1'b1, 14, 1'b0, 8'd2, 0};
    vecs[13] = '{1'b0,  9, 1'b0, 8'd2, 1};
    vecs[14] = '{1'b1, 14, 1'b0, 8'd3, 2};

    rst_n = 1'b0;
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_level", int'(btn_level), 0);
    check("reset_press_pulse", int'(press_pulse), 0);
    check("reset_release_pulse", int'(release_pulse), 0);
    check("reset_count", int'(press_count), 0);
    check("reset_long", int'(long_press), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].btn, vecs[i].evt);
      repeat (vecs[i].hold) @(negedge clk);
      check($sformatf("vec%0d_level", i), int'(btn_level), int'(vecs[i].lvl));
      check($sformatf("vec%0d_count", i), int'(press_count), int'(vecs[i].cnt));
    end

    // Reset four cycles into PRESS_WAIT with the button still held.
    drive(1'b0, 0);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_level", int'(btn_level), 0);
    check("midreset_count", int'(press_count), 0);
    check("midreset_pulse", int'(press_pulse), 0);
    exp_count = 8'd0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_count = exp_count + 8'd1;
    sb.push_back('{1, cyc + LAT, exp_count});
    repeat (14) @(negedge clk);
    check("postreset_level", int'(btn_level), 1);
    check("postreset_count", int'(press_count), 1);
    drive(1'b1, 2);
    repeat (14) @(negedge clk);

    #1 rst_n = 1'b0;
    exp_count = 8'd0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("wrap_start_count", int'(press_count), 0);

    rel_before = rel_seen;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1);
      repeat (14) @(negedge clk);
      drive(1'b1, 2);
      repeat (14) @(negedge clk);
    end
    check("wrap_count", int'(press_count), 0);
    check("wrap_releases", rel_seen - rel_before, 256);

    lp_before = lp_seen;
    drive(1'b0, 1);
    repeat (60) @(negedge clk);
    check("long_hold_level", int'(btn_level), 1);
    check("long_press_pulses", lp_seen - lp_before, LP_EXP);
    drive(1'b1, 2);
    repeat (14) @(negedge clk);
    check("long_release_level", int'(btn_level), 0);

    repeat (20) @(negedge clk);
    check("long_press_total", lp_seen, LP_EXP);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
